// File: rtl/apb_cemf_regbank_param.sv
// ============================================================================
// Module   : apb_cemf_regbank_param
// Brief    : Parametrised APB register bank (ID, STATUS, SYS, W1C IRQ_STAT,
//            NUM_CFG config registers) with a memory window at MEM_BASE that
//            is forwarded to an external RAM port with wait states and a
//            bus timeout. A two-state access FSM (IDLE/ACCESS) gives defined
//            pready/pslverr timing.
// Options  : APB_REGBANK_WLOCK_EN - SYS bit 31 becomes a sticky LOCK that
//            blocks CFG writes (they complete with pslverr=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cemf_regbank_param #(
    parameter int                          ADDR_W      = 16,
    parameter int                          DATA_W      = 32,
    parameter int                          NUM_CFG     = 5,
    parameter int                          CFG_W       = 24,
    parameter logic [NUM_CFG*CFG_W-1:0]    CFG_RST     = '0,
    parameter logic [DATA_W-1:0]           ID_VALUE    = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]           MEM_BASE    = 16'h0008,
    parameter int                          MEM_DEPTH   = 1024,
    parameter int                          MEM_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [DATA_W-1:0]        pwdata,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        status_i,
    input  logic [DATA_W-1:0]        irq_event_i,
    input  logic                     clr_sys_reg,
    output logic [DATA_W-1:0]        data_system_o,
    output logic [NUM_CFG*CFG_W-1:0] cfg_o,
    output logic                     irq_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RG_REG = 2'd0,
        RG_MEM = 2'd1,
        RG_UNM = 2'd2
    } region_t;

    // Decode bounds are one bit wider than paddr so the memory window end
    // cannot wrap around for windows reaching the top of the address space.
    localparam logic [ADDR_W:0] REG_END = (ADDR_W+1)'(4 + NUM_CFG);
    localparam logic [ADDR_W:0] CFG_LO  = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] MEM_LO  = (ADDR_W+1)'(int'(MEM_BASE));
    localparam logic [ADDR_W:0] MEM_HI  = (ADDR_W+1)'(int'(MEM_BASE) + MEM_DEPTH);
    localparam int              CNT_W   = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t             state;
    region_t            region;
    region_t            dec;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W:0]    addr_x;

    logic [DATA_W-1:0]  sys_q;
    logic [DATA_W-1:0]  sys_wdata;
    logic [DATA_W-1:0]  irq_stat;
    logic [DATA_W-1:0]  w1c_mask;
    logic [CFG_W-1:0]   cfg_q [NUM_CFG];
    logic [DATA_W-1:0]  reg_rdata;

    logic               reg_wr;
    logic               cfg_hit;
    logic               lock;
    logic               lock_err;

`ifdef APB_REGBANK_WLOCK_EN
    // LOCK is sticky: a SYS write can set bit 31 but never clear it.
    assign lock = sys_q[31];
    always_comb begin
        sys_wdata     = pwdata;
        sys_wdata[31] = pwdata[31] | sys_q[31];
    end
`else
    assign lock      = 1'b0;
    assign sys_wdata = pwdata;
`endif

    // Region decode of the live address, latched by the FSM in the setup phase.
    always_comb begin
        addr_x = {1'b0, paddr};
        if (addr_x < REG_END) begin
            dec = RG_REG;
        end else if (addr_x >= MEM_LO && addr_x < MEM_HI) begin
            dec = RG_MEM;
        end else begin
            dec = RG_UNM;
        end
    end

    // Register-region write strobes; they only fire in the completing cycle.
    always_comb begin
        reg_wr   = (state == ACCESS) && psel && (region == RG_REG) && pwrite;
        cfg_hit  = (addr_x >= CFG_LO) && (addr_x < REG_END);
        lock_err = reg_wr && cfg_hit && lock;
        w1c_mask = (reg_wr && paddr == ADDR_W'(3)) ? pwdata : '0;
    end

    // Register read mux; CFG values are zero-extended to the bus width.
    always_comb begin
        reg_rdata = '0;
        if (paddr == ADDR_W'(0)) begin
            reg_rdata = ID_VALUE;
        end else if (paddr == ADDR_W'(1)) begin
            reg_rdata = status_i;
        end else if (paddr == ADDR_W'(2)) begin
            reg_rdata = sys_q;
        end else if (paddr == ADDR_W'(3)) begin
            reg_rdata = irq_stat;
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (paddr == ADDR_W'(4 + i)) begin
                reg_rdata[CFG_W-1:0] = cfg_q[i];
            end
        end
    end

    // APB response and memory strobes, derived from the registered FSM state.
    // pready has to follow mem_ready in the same cycle, hence no extra flop.
    always_comb begin
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        if (state == ACCESS) begin
            if (region == RG_MEM) begin
                mem_en   = 1'b1;
                mem_we   = pwrite;
                mem_addr = paddr - MEM_BASE;
            end
            if (psel) begin
                case (region)
                    RG_REG: begin
                        pready  = 1'b1;
                        pslverr = lock_err;
                        if (!pwrite) begin
                            prdata = reg_rdata;
                        end
                    end
                    RG_MEM: begin
                        if (mem_ready) begin
                            pready = 1'b1;
                            if (!pwrite) begin
                                prdata = mem_rdata;
                            end
                        end else if (cnt == CNT_LAST) begin
                            pready  = 1'b1;
                            pslverr = 1'b1;
                        end
                    end
                    default: begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end
                endcase
            end
        end
    end

    assign mem_wdata = pwdata;

    // Access FSM: setup phase latches the region, ACCESS waits for completion,
    // a dropped psel aborts back to IDLE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            region <= RG_REG;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state  <= ACCESS;
                        region <= dec;
                        cnt    <= '0;
                    end
                end
                ACCESS: begin
                    if (!psel || pready) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SYS, IRQ_STAT, CFG storage and the registered interrupt line.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sys_q    <= '0;
            irq_stat <= '0;
            irq_o    <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RST[i*CFG_W +: CFG_W];
            end
        end else begin
            if (clr_sys_reg) begin
                sys_q <= '0;
            end else if (reg_wr && paddr == ADDR_W'(2)) begin
                sys_q <= sys_wdata;
            end
            // New events win over a simultaneous write-1-to-clear.
            irq_stat <= (irq_stat & ~w1c_mask) | irq_event_i;
            irq_o    <= |irq_stat;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (reg_wr && !lock && paddr == ADDR_W'(4 + i)) begin
                    cfg_q[i] <= pwdata[CFG_W-1:0];
                end
            end
        end
    end

    // Flatten the CFG array onto the output bus.
    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_o[i*CFG_W +: CFG_W] = cfg_q[i];
        end
    end

    assign data_system_o = sys_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_cemf_regbank_param.sv
// ============================================================================
// Module   : tb_apb_cemf_regbank_param
// Brief    : Directed self-checking bench for apb_cemf_regbank_param with a
//            scoreboard queue of expected APB responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cemf_regbank_param;

    localparam int              NCFG   = 4;
    localparam int              CW     = 24;
    localparam logic [NCFG*CW-1:0] CRST = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    localparam logic [31:0]     ID     = 32'hCE3F_0001;

    logic               clock = 1'b0;
    logic               rst_n;
    logic               psel, penable, pwrite;
    logic [15:0]        paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready, pslverr;
    logic               mem_en, mem_we;
    logic [15:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic [31:0]        status_i;
    logic [31:0]        irq_event_i;
    logic               clr_sys_reg;
    logic [31:0]        data_system_o;
    logic [NCFG*CW-1:0] cfg_o;
    logic               irq_o;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int mem_lat = -1;
    int mem_cnt = 0;

    logic [15:0] obs_maddr;
    logic        obs_mwe;
    logic [31:0] obs_mwdata;

    apb_cemf_regbank_param #(
        .ADDR_W(16), .DATA_W(32), .NUM_CFG(NCFG), .CFG_W(CW), .CFG_RST(CRST),
        .ID_VALUE(ID), .MEM_BASE(16'h0008), .MEM_DEPTH(1024), .MEM_TIMEOUT(16)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .status_i(status_i), .irq_event_i(irq_event_i),
        .clr_sys_reg(clr_sys_reg), .data_system_o(data_system_o),
        .cfg_o(cfg_o), .irq_o(irq_o)
    );

    always #5 clock = ~clock;

    // Memory model: ready after mem_lat wait cycles (negative = never),
    // read data is a fixed pattern tagged with the word offset.
    always @(posedge clock) begin
        if (!mem_en) mem_cnt <= 0;
        else         mem_cnt <= mem_cnt + 1;
    end
    assign mem_ready = mem_en && (mem_lat >= 0) && (mem_cnt == mem_lat);
    assign mem_rdata = {16'hA5A5, mem_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; the expected response is queued before driving and
    // popped when pready is seen.
    task automatic apb(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_cyc);
        exp_t e;
        int   cyc;
        sb.push_back('{rd: exp_rd, err: exp_err, cyc: exp_cyc});
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clock); #1;
        penable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!pready && cyc < 100);
        e = sb.pop_front();
        if (!pready) begin
            total++;
            bad++;
            $error("FAIL %s_pready observed=0 expected=1 (no completion)", tag);
        end else begin
            check({tag, "_rd"}, prdata, e.rd);
            check({tag, "_err"}, {31'b0, pslverr}, {31'b0, e.err});
            check({tag, "_cyc"}, cyc, e.cyc);
        end
        obs_maddr  = mem_addr;
        obs_mwe    = mem_we;
        obs_mwdata = mem_wdata;
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; status_i = 32'h1234_5678;
        irq_event_i = '0; clr_sys_reg = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_irq_o", {31'b0, irq_o}, 32'h0);
        check("rst_sys", data_system_o, 32'h0);
        for (int i = 0; i < NCFG; i++)
            check($sformatf("rst_cfg%0d", i), {8'h0, cfg_o[i*CW +: CW]}, {8'h0, CRST[i*CW +: CW]});
        @(posedge clock); #1;
        rst_n = 1'b1;

        // Full register map readback
        apb("rd_id",     1'b0, 16'd0, 32'h0, ID,           1'b0, 1);
        apb("rd_status", 1'b0, 16'd1, 32'h0, 32'h1234_5678, 1'b0, 1);
        apb("rd_sys",    1'b0, 16'd2, 32'h0, 32'h0,         1'b0, 1);
        apb("rd_irq",    1'b0, 16'd3, 32'h0, 32'h0,         1'b0, 1);
        for (int i = 0; i < NCFG; i++)
            apb($sformatf("rd_cfg%0d", i), 1'b0, 16'(4 + i), 32'h0,
                {8'h0, CRST[i*CW +: CW]}, 1'b0, 1);

        // CFG write / readback, upper bits dropped
        apb("wr_cfg1", 1'b1, 16'd5, 32'h00AB_CDEF, 32'h0, 1'b0, 1);
        check("cfg1_out", {8'h0, cfg_o[CW +: CW]}, 32'h00AB_CDEF);
        apb("rb_cfg1", 1'b0, 16'd5, 32'h0, 32'h00AB_CDEF, 1'b0, 1);
        apb("wr_cfg1_ff", 1'b1, 16'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        apb("rb_cfg1_ff", 1'b0, 16'd5, 32'h0, 32'h00FF_FFFF, 1'b0, 1);
        check("cfg0_untouched", {8'h0, cfg_o[0 +: CW]}, 32'h0011_1111);

        // RO write ignored without error; SYS RW including bit 31
        apb("wr_id", 1'b1, 16'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
        apb("rb_id", 1'b0, 16'd0, 32'h0, ID, 1'b0, 1);
        apb("wr_sys", 1'b1, 16'd2, 32'h8000_0055, 32'h0, 1'b0, 1);
        check("sys_out", data_system_o, 32'h8000_0055);
        apb("wr_cfg3_unlocked", 1'b1, 16'd7, 32'h0000_0077, 32'h0, 1'b0, 1);
        check("cfg3_out", {8'h0, cfg_o[3*CW +: CW]}, 32'h0000_0077);

        // Interrupt set and registered irq_o
        @(posedge clock); #1;
        irq_event_i = 32'h5;
        @(posedge clock); #1;
        irq_event_i = 32'h0;
        @(negedge clock);
        check("irq_o_lat0", {31'b0, irq_o}, 32'h0);
        @(negedge clock);
        check("irq_o_set", {31'b0, irq_o}, 32'h1);
        apb("rd_irq5", 1'b0, 16'd3, 32'h0, 32'h5, 1'b0, 1);

        // Set beats W1C on the same bit
        irq_event_i = 32'h4;
        apb("w1c_vs_set", 1'b1, 16'd3, 32'h4, 32'h0, 1'b0, 1);
        irq_event_i = 32'h0;
        apb("rd_irq_keep", 1'b0, 16'd3, 32'h0, 32'h5, 1'b0, 1);
        apb("w1c_all", 1'b1, 16'd3, 32'h5, 32'h0, 1'b0, 1);
        apb("rd_irq_clr", 1'b0, 16'd3, 32'h0, 32'h0, 1'b0, 1);
        check("irq_o_clr", {31'b0, irq_o}, 32'h0);

        // Memory write with three wait cycles
        mem_lat = 3;
        apb("mem_wr", 1'b1, 16'h0010, 32'hCAFE_0001, 32'h0, 1'b0, 4);
        check("mem_addr", {16'h0, obs_maddr}, 32'h0000_0008);
        check("mem_we", {31'b0, obs_mwe}, 32'h1);
        check("mem_wdata", obs_mwdata, 32'hCAFE_0001);
        // Zero-wait read and the last word of the window
        mem_lat = 0;
        apb("mem_rd0", 1'b0, 16'h0020, 32'h0, 32'hA5A5_0018, 1'b0, 1);
        mem_lat = 1;
        apb("mem_rd_last", 1'b0, 16'h0407, 32'h0, 32'hA5A5_03FF, 1'b0, 2);
        // Timeout
        mem_lat = -1;
        apb("mem_tmo", 1'b0, 16'h0030, 32'h0, 32'h0, 1'b1, 16);
        @(negedge clock);
        check("mem_en_after_tmo", {31'b0, mem_en}, 32'h0);

        // Unmapped: just past the window and top of the address space
        apb("unm_rd", 1'b0, 16'h0408, 32'h0, 32'h0, 1'b1, 1);
        apb("unm_wr", 1'b1, 16'hFFFF, 32'h1234_5678, 32'h0, 1'b1, 1);

        // Protocol error in IDLE and aborted transfer leave CFG untouched
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'd6; pwdata = 32'h0099_9999;
        repeat (2) @(posedge clock);
        #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; paddr = 16'd6;
        @(posedge clock); #1;
        psel = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("cfg2_no_write", {8'h0, cfg_o[2*CW +: CW]}, 32'h0033_3333);

        // SYS clear wins over a simultaneous write
        clr_sys_reg = 1'b1;
        apb("sys_clr_wr", 1'b1, 16'd2, 32'h1111_1111, 32'h0, 1'b0, 1);
        clr_sys_reg = 1'b0;
        check("sys_cleared", data_system_o, 32'h0);
        apb("wr_sys2", 1'b1, 16'd2, 32'h0000_00A5, 32'h0, 1'b0, 1);

        // Reset in the middle of a memory wait
        mem_lat = -1;
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0040;
        @(posedge clock); #1;
        penable = 1'b1;
        repeat (3) @(negedge clock);
        check("mid_mem_en", {31'b0, mem_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_mid_pready", {31'b0, pready}, 32'h0);
        check("rst_mid_sys", data_system_o, 32'h0);
        check("rst_mid_cfg1", {8'h0, cfg_o[CW +: CW]}, 32'h0022_2222);
        psel = 1'b0; penable = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        apb("post_rst_id", 1'b0, 16'd0, 32'h0, ID, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
